// File: rtl/count_pwm_gen_pkg.sv
// Shared types for the count-following PWM generator: FSM states, the
// one-hot event classification of the incoming count, and the default count width.
package count_pwm_gen_pkg;

   localparam int COUNT_W = 8;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_SYNC = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

   // Bit positions of each event inside event_t.
   typedef enum logic [1:0] {
      EV_STEP  = 2'd0,
      EV_WRAP  = 2'd1,
      EV_STALL = 2'd2,
      EV_DISC  = 2'd3
   } event_e;

   // Exactly one field is set every cycle.
   typedef struct packed {
      logic disc;
      logic stall;
      logic wrap;
      logic step;
   } event_t;

endpackage

// File: rtl/count_pwm_gen_if.sv
// Bundle of the count input, duty handshake and status outputs of count_pwm_gen.
// The master side is the environment (counter + duty sender); the slave is the block.
interface count_pwm_gen_if #(
   parameter int WIDTH  = 8,
   parameter int WRAP_W = 16
);
   logic [WIDTH-1:0]  count;
   logic [WIDTH-1:0]  duty_in;
   logic              duty_valid;
   logic              duty_ready;
   logic              pwm_out;
   logic              wrap_pulse;
   logic              err_pulse;
   logic [WRAP_W-1:0] wrap_count;

   modport master (
      output count, duty_in, duty_valid,
      input  duty_ready, pwm_out, wrap_pulse, err_pulse, wrap_count
   );

   modport slave (
      input  count, duty_in, duty_valid,
      output duty_ready, pwm_out, wrap_pulse, err_pulse, wrap_count
   );
endinterface

// File: rtl/count_pwm_gen_count_tracker.sv
// Remembers last cycle's count and classifies the current one relative to it
// as step, wrap (MAX->0), stall (unchanged) or discontinuity.
module count_pwm_gen_count_tracker
   import count_pwm_gen_pkg::*;
#(
   parameter int WIDTH = COUNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_i,
   output event_t           event_o
);

   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_inc_s;

   // Capture the count every cycle so the next sample can be compared to it.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= {WIDTH{1'b0}};
      end else begin
         prev_q <= count_i;
      end
   end

   // Classify the current sample; wrap takes priority over plain step.
   always_comb begin
      event_o    = '0;
      prev_inc_s = prev_q + {{(WIDTH-1){1'b0}}, 1'b1};
      if ((prev_q == {WIDTH{1'b1}}) && (count_i == {WIDTH{1'b0}})) begin
         event_o.wrap = 1'b1;
      end else if (count_i == prev_inc_s) begin
         event_o.step = 1'b1;
      end else if (count_i == prev_q) begin
         event_o.stall = 1'b1;
      end else begin
         event_o.disc = 1'b1;
      end
   end

endmodule

// File: rtl/count_pwm_gen.sv
// PWM generator that follows a free-running upstream counter. It locks on the
// first wrap, drops out on a discontinuity, and swaps in a new duty value only
// at a wrap so that every PWM period is built from a single duty value.
module count_pwm_gen
   import count_pwm_gen_pkg::*;
#(
   parameter int               WIDTH      = COUNT_W,
   parameter int               WRAP_W     = 16,
   parameter logic [WIDTH-1:0] DUTY_RESET = 8'h80
) (
   input logic            clk,
   input logic            reset,
   count_pwm_gen_if.slave bus
);

   state_e            state_q, state_d;
   event_t            ev_s;
   logic              wrap_s, hs_s, load_s;
   logic [WIDTH-1:0]  active_q, active_d;
   logic [WIDTH-1:0]  pending_q, pending_d;
   logic [WIDTH-1:0]  eff_duty_s;
   logic              pending_full_q, pending_full_d;
   logic              pwm_q, pwm_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic              err_q, err_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

   count_pwm_gen_count_tracker #(.WIDTH(WIDTH)) u_tracker (
      .clk     (clk),
      .reset   (reset),
      .count_i (bus.count),
      .event_o (ev_s)
   );

   // The previous count is meaningless in INIT, so no wrap is recognised there.
   assign wrap_s = (state_q != ST_INIT) && ev_s.wrap;
   assign hs_s   = bus.duty_valid && !pending_full_q;
   assign load_s = wrap_s && pending_full_q;

   // Lock/unlock FSM: lock on a wrap, drop back to SYNC on a discontinuity while running.
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_SYNC;
         ST_SYNC: begin
            if (wrap_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_SYNC;
            end
         end
         ST_RUN: begin
            if (ev_s.disc) begin
               state_d = ST_SYNC;
               err_d   = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Duty double-buffer, wrap counter and PWM compare next values.
   always_comb begin
      active_d       = active_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      if (load_s) begin
         active_d       = pending_q;
         pending_full_d = 1'b0;
      end else begin
         active_d = active_q;
      end
      // A handshake is only possible while pending is empty, so it never collides with a load.
      if (hs_s) begin
         pending_d      = bus.duty_in;
         pending_full_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
      eff_duty_s   = load_s ? pending_q : active_q;
      wrap_pulse_d = wrap_s;
      wrap_count_d = wrap_count_q + {{(WRAP_W-1){1'b0}}, wrap_s};
      pwm_d        = (state_d == ST_RUN) && (bus.count < eff_duty_s);
   end

   // State and output registers; reset overrides every event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_INIT;
         active_q       <= DUTY_RESET;
         pending_q      <= {WIDTH{1'b0}};
         pending_full_q <= 1'b0;
         pwm_q          <= 1'b0;
         wrap_pulse_q   <= 1'b0;
         err_q          <= 1'b0;
         wrap_count_q   <= {WRAP_W{1'b0}};
      end else begin
         state_q        <= state_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         pwm_q          <= pwm_d;
         wrap_pulse_q   <= wrap_pulse_d;
         err_q          <= err_d;
         wrap_count_q   <= wrap_count_d;
      end
   end

   assign bus.duty_ready = !pending_full_q;
   assign bus.pwm_out    = pwm_q;
   assign bus.wrap_pulse = wrap_pulse_q;
   assign bus.err_pulse  = err_q;
   assign bus.wrap_count = wrap_count_q;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Bench for count_pwm_gen: a behavioural upstream counter and duty sender are
// driven from a step table; a reference model pushes expected outputs into a
// queue each cycle and they are popped and compared after the clock edge.
module tb_count_pwm_gen;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   count_pwm_gen_if #(.WIDTH(8), .WRAP_W(16)) bus ();
   count_pwm_gen_if #(.WIDTH(8), .WRAP_W(2))  bus2 ();

   count_pwm_gen #(.WIDTH(8), .WRAP_W(16), .DUTY_RESET(8'h80)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
   count_pwm_gen #(.WIDTH(8), .WRAP_W(2), .DUTY_RESET(8'h80)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   assign bus2.count      = bus.count;
   assign bus2.duty_in    = 8'h00;
   assign bus2.duty_valid = 1'b0;

   typedef struct {
      logic pwm;
      logic wrap;
      logic err;
      logic ready;
      int   wc;
   } exp_t;

   localparam int K_RESET = 0, K_COUNT = 1, K_SEND = 2, K_HOLD = 3, K_MEAS = 4, K_WRAPS = 5;
   typedef struct {
      int         kind;
      int         a;
      int         b;
      logic [7:0] duty;
   } step_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;

   // reference model state
   int         m_state;
   logic [7:0] m_prev, m_active, m_pend;
   logic       m_full, m_pwm;
   int         m_wc;

   // upstream counter and duty sender
   logic [7:0] cnt_v;
   logic       snd_v;
   logic [7:0] snd_d;
   int         hi_cnt, err_cnt, wrap_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [7:0] c, input logic v, input logic [7:0] d, input logic rst);
      exp_t       e;
      logic       wrap, disc, hs, err;
      logic [7:0] nxt, eff;
      int         ns;
      if (rst) begin
         m_state = 0; m_active = 8'h80; m_full = 1'b0; m_wc = 0; m_pwm = 1'b0;
         e = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      end else begin
         nxt  = m_prev + 8'd1;
         wrap = (m_state != 0) && (m_prev == 8'hFF) && (c == 8'h00);
         disc = (m_state != 0) && !wrap && (c != m_prev) && (c != nxt);
         ns   = (m_state == 0) ? 1 : (m_state == 1) ? (wrap ? 2 : 1) : (disc ? 1 : 2);
         err  = (m_state == 2) && disc;
         hs   = v && !m_full;
         eff  = m_active;
         if (wrap && m_full) begin
            eff = m_pend; m_active = m_pend; m_full = 1'b0;
         end
         if (hs) begin
            m_pend = d; m_full = 1'b1;
         end
         if (wrap) m_wc++;
         m_pwm   = (ns == 2) && (c < eff);
         m_state = ns;
         e = '{m_pwm, wrap, err, !m_full, m_wc};
      end
      m_prev = c;
      sbq.push_back(e);
   endtask

   task automatic cycle(input logic [7:0] c, input logic v, input logic [7:0] d, input logic rst);
      exp_t e;
      reset = rst; bus.count = c; bus.duty_valid = v; bus.duty_in = d;
      model_step(c, v, d, rst);
      @(posedge clk); #1;
      e = sbq.pop_front();
      chk("pwm_out",       {31'd0, bus.pwm_out},    {31'd0, e.pwm});
      chk("wrap_pulse",    {31'd0, bus.wrap_pulse}, {31'd0, e.wrap});
      chk("err_pulse",     {31'd0, bus.err_pulse},  {31'd0, e.err});
      chk("duty_ready",    {31'd0, bus.duty_ready}, {31'd0, e.ready});
      chk("wrap_count",    {16'd0, bus.wrap_count}, e.wc & 32'hFFFF);
      chk("wrap_pulse_w2", {31'd0, bus2.wrap_pulse}, {31'd0, e.wrap});
      chk("wrap_count_w2", {30'd0, bus2.wrap_count}, e.wc & 32'h3);
      hi_cnt  += int'(bus.pwm_out);
      err_cnt += int'(bus.err_pulse);
      wrap_seen = int'(bus2.wrap_pulse);
   endtask

   // One counting clock; the sender drops valid after a cycle in which ready was high.
   task automatic count_step();
      logic hs_now;
      hs_now = snd_v && bus.duty_ready;
      cycle(cnt_v, snd_v, snd_d, 1'b0);
      cnt_v = cnt_v + 8'd1;
      if (hs_now) snd_v = 1'b0;
   endtask

   step_t steps[$];
   int    wseq[5] = '{1, 2, 3, 0, 1};

   initial begin
      int n;
      snd_v = 1'b0; snd_d = 8'h00; cnt_v = 8'h00; m_prev = 8'h00; m_pend = 8'h00;
      m_state = 0; m_active = 8'h80; m_full = 1'b0; m_wc = 0; m_pwm = 1'b0;
      hi_cnt = 0; err_cnt = 0; wrap_seen = 0;
      steps = '{
         '{K_RESET, 2,   0, 8'h00},
         '{K_COUNT, 600, 0, 8'h00},
         '{K_MEAS,  128, 0, 8'h00},
         '{K_SEND,  10,  0, 8'h40},
         '{K_MEAS,  64,  0, 8'h00},
         '{K_SEND,  0,   0, 8'h10},
         '{K_MEAS,  16,  0, 8'h00},
         '{K_HOLD,  37,  20, 8'h00},
         '{K_COUNT, 600, 0, 8'h00},
         '{K_MEAS,  16,  0, 8'h00},
         '{K_SEND,  5,   0, 8'h00},
         '{K_MEAS,  0,   0, 8'h00},
         '{K_SEND,  5,   0, 8'hFF},
         '{K_MEAS,  255, 0, 8'h00},
         '{K_RESET, 1,   0, 8'h00},
         '{K_WRAPS, 5,   0, 8'h00},
         '{K_COUNT, 100, 0, 8'h00},
         '{K_RESET, 1,   0, 8'h00},
         '{K_COUNT, 20,  0, 8'h00}
      };
      foreach (steps[s]) begin
         case (steps[s].kind)
            K_RESET: begin
               snd_v = 1'b0;
               for (int i = 0; i < steps[s].a; i++) cycle(cnt_v, 1'b0, 8'h00, 1'b1);
               cnt_v = 8'h00;
            end
            K_COUNT: for (int i = 0; i < steps[s].a; i++) count_step();
            K_SEND: begin
               n = 0;
               while (cnt_v != steps[s].a[7:0] && n < 300) begin count_step(); n++; end
               snd_v = 1'b1; snd_d = steps[s].duty;
               n = 0;
               while (snd_v && n < 600) begin count_step(); n++; end
               chk("send_handshake_done", {31'd0, snd_v}, 32'd0);
               snd_v = 1'b0;
            end
            K_HOLD: begin
               n = 0;
               while (cnt_v != steps[s].a[7:0] && n < 300) begin count_step(); n++; end
               count_step();
               n = m_wc; err_cnt = 0;
               for (int i = 0; i < steps[s].b; i++) cycle(8'h00, 1'b0, 8'h00, 1'b0);
               chk("err_once", err_cnt, 1);
               chk("hold_no_wrap", {16'd0, bus.wrap_count}, n & 32'hFFFF);
               cnt_v = 8'h01;
            end
            K_MEAS: begin
               n = 0;
               while (cnt_v != 8'h00 && n < 300) begin count_step(); n++; end
               hi_cnt = 0;
               for (int i = 0; i < 256; i++) count_step();
               chk("period_high", hi_cnt, steps[s].a);
            end
            K_WRAPS: begin
               for (int w = 0; w < steps[s].a; w++) begin
                  n = 0; wrap_seen = 0;
                  while (wrap_seen == 0 && n < 300) begin count_step(); n++; end
                  chk("wrap_seq_w2", {30'd0, bus2.wrap_count}, wseq[w]);
               end
            end
            default: chk("bad_step_kind", steps[s].kind, 0);
         endcase
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
